// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave view belongs to the arbiter. The master view belongs to the
// environment, which holds both requesters and the memory.
interface data_memory_arbiter_if;
  // Requester side
  logic        iReq0;
  logic        iReq1;
  logic        iWe0;
  logic        iWe1;
  logic [31:0] iAddr0;
  logic [31:0] iAddr1;
  logic [31:0] iWData0;
  logic [31:0] iWData1;
  logic        oAck0;
  logic        oAck1;
  logic        oErr0;
  logic        oErr1;
  logic [31:0] oRData;
  // Memory side
  logic        oMemWrite;
  logic        oMemRead;
  logic [31:0] oMemAddress;
  logic [31:0] oMemData;
  logic [31:0] iMemData;

  modport slave (
    input  iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iMemData,
    output oAck0, oAck1, oErr0, oErr1, oRData,
    output oMemWrite, oMemRead, oMemAddress, oMemData
  );

  modport master (
    output iReq0, iReq1, iWe0, iWe1, iAddr0, iAddr1, iWData0, iWData1, iMemData,
    input  oAck0, oAck1, oErr0, oErr1, oRData,
    input  oMemWrite, oMemRead, oMemAddress, oMemData
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter that shares a single-port data memory between port 0
// (the CPU load/store unit) and port 1 (the debug/DMA loader).
// Each transaction takes three cycles: IDLE (arbitrate and latch),
// ACCESS (drive the memory) and DONE (acknowledge the winner).
// Range and alignment errors block both memory strobes.
module data_memory_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int          DEPTH     = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  data_memory_arbiter_if.slave  bus
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_rr;      // port that wins when both ports request
  logic        r_id;      // winner of the transaction in flight
  logic        r_we;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_any_req;
  logic        w_win;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_offset;
  logic        w_err;

  logic        w_ack0;
  logic        w_ack1;
  logic        w_err0;
  logic        w_err1;
  logic        w_mem_write;
  logic        w_mem_read;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_data;

  // Winner selection: a lone requester wins; on a tie the rr pointer decides.
  assign w_any_req   = bus.iReq0 | bus.iReq1;
  assign w_win       = (bus.iReq0 & bus.iReq1) ? r_rr : bus.iReq1;
  assign w_sel_we    = w_win ? bus.iWe1    : bus.iWe0;
  assign w_sel_addr  = w_win ? bus.iAddr1  : bus.iAddr0;
  assign w_sel_wdata = w_win ? bus.iWData1 : bus.iWData0;

  // Error check. The offset may wrap when the address lies below the base,
  // but the lower-bound test already flags that case.
  assign w_offset = w_sel_addr - BASE_ADDR;
  assign w_err    = (w_sel_addr[1:0] != 2'b00) ||
                    (w_sel_addr < BASE_ADDR)    ||
                    ((w_offset >> 2) >= DEPTH_W);

  // State register. Reset returns the FSM to IDLE at once, which also drops
  // the strobes and the ack asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next state, plus the memory and ack outputs decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;
    w_err0       = 1'b0;
    w_err1       = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_addr   = '0;
    w_mem_data   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_state_next = ACCESS;
      end
      ACCESS: begin
        w_mem_addr   = r_addr;
        w_mem_data   = r_wdata;
        w_mem_write  = r_we & ~r_err;
        w_mem_read   = ~r_we & ~r_err;
        w_state_next = DONE;
      end
      DONE: begin
        w_ack0       = ~r_id;
        w_ack1       = r_id;
        w_err0       = ~r_id & r_err;
        w_err1       = r_id & r_err;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch the winner in IDLE, capture the read data in
  // ACCESS, and hand priority to the other port in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr    <= 1'b0;
      r_id    <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_id    <= w_win;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= w_err;
          end
        end
        ACCESS: begin
          r_rdata <= (r_we | r_err) ? 32'h0 : bus.iMemData;
        end
        DONE: begin
          r_rr <= ~r_id;
        end
        default: ;
      endcase
    end
  end

  assign bus.oAck0       = w_ack0;
  assign bus.oAck1       = w_ack1;
  assign bus.oErr0       = w_err0;
  assign bus.oErr1       = w_err1;
  assign bus.oRData      = r_rdata;
  assign bus.oMemWrite   = w_mem_write;
  assign bus.oMemRead    = w_mem_read;
  assign bus.oMemAddress = w_mem_addr;
  assign bus.oMemData    = w_mem_data;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter. It holds a behavioural memory driven by the
// DUT strobes, a transaction-level reference model that is checked every
// cycle, directed scenarios with literal expectations, and random traffic.
module tb_data_memory_arbiter;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          DEPTH = 256;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  data_memory_arbiter_if bus();

  data_memory_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Memory attached to the DUT: asynchronous read, write on the clock edge.
  logic [31:0] mem [DEPTH];
  logic [31:0] mem_off;
  assign mem_off      = bus.oMemAddress - BASE;
  assign bus.iMemData = mem[mem_off[9:2]];
  always @(posedge clock) if (bus.oMemWrite) mem[mem_off[9:2]] <= bus.oMemData;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one pending transaction and its accept cycle.
  logic [31:0] model_mem [DEPTH];
  bit          pend = 0;
  int          p_n;
  bit          p_port, p_we, p_err;
  logic [31:0] p_addr, p_wdata, p_rdata;
  bit          m_ptr = 0;

  // Ack log, filled by the compare process.
  int          ack_port [$];
  int          ack_cyc  [$];
  logic [31:0] ack_rdata[$];
  int          ack_err  [$];

  function automatic bit model_err(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    if (ua % 4 != 0) return 1'b1;
    if (ua < longint'(BASE)) return 1'b1;
    if ((ua - longint'(BASE)) / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  // Compare process: checks the outputs at every falling edge, then advances the model.
  initial begin
    forever begin
      bit e_ack0, e_ack1, e_err, e_wr, e_rd;
      logic [31:0] e_addr, e_data;
      @(negedge clock);
      e_ack0 = 0; e_ack1 = 0; e_err = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_data = '0;
      if (reset_n && pend) begin
        if (cyc == p_n + 1) begin
          e_wr = p_we & ~p_err;  e_rd = ~p_we & ~p_err;
          e_addr = p_addr;       e_data = p_wdata;
        end else if (cyc == p_n + 2) begin
          e_ack0 = ~p_port; e_ack1 = p_port; e_err = p_err;
        end
      end
      chk("ack0",     32'(bus.oAck0),     32'(e_ack0));
      chk("ack1",     32'(bus.oAck1),     32'(e_ack1));
      chk("memwrite", 32'(bus.oMemWrite), 32'(e_wr));
      chk("memread",  32'(bus.oMemRead),  32'(e_rd));
      chk("memaddr",  bus.oMemAddress,    e_addr);
      chk("memdata",  bus.oMemData,       e_data);
      if (!reset_n) chk("rdata_reset", bus.oRData, 32'h0);
      if (e_ack0 || e_ack1) begin
        chk("err",   32'(e_ack0 ? bus.oErr0 : bus.oErr1), 32'(e_err));
        chk("rdata", bus.oRData, p_rdata);
      end else begin
        chk("err_idle", 32'({bus.oErr0, bus.oErr1}), 32'h0);
      end
      if (bus.oAck0 || bus.oAck1) begin
        ack_port.push_back(bus.oAck1 ? 1 : 0);
        ack_cyc.push_back(cyc);
        ack_rdata.push_back(bus.oRData);
        ack_err.push_back(int'(bus.oAck1 ? bus.oErr1 : bus.oErr0));
      end
      // Advance the model.
      if (!reset_n) begin
        pend = 0; m_ptr = 0;
      end else if (pend) begin
        if (cyc == p_n + 1) begin
          if (p_we || p_err) p_rdata = 32'h0;
          else               p_rdata = model_mem[(p_addr - BASE) / 4];
          if (p_we && !p_err) model_mem[(p_addr - BASE) / 4] = p_wdata;
        end else if (cyc == p_n + 2) begin
          pend = 0; m_ptr = ~p_port;
        end
      end else if (bus.iReq0 || bus.iReq1) begin
        pend   = 1;
        p_n    = cyc;
        p_port = (bus.iReq0 && bus.iReq1) ? m_ptr : bus.iReq1;
        p_we   = p_port ? bus.iWe1    : bus.iWe0;
        p_addr = p_port ? bus.iAddr1  : bus.iAddr0;
        p_wdata= p_port ? bus.iWData1 : bus.iWData0;
        p_err  = model_err(p_addr);
      end
    end
  end

  task automatic clear_log();
    ack_port.delete(); ack_cyc.delete(); ack_rdata.delete(); ack_err.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.iReq0 = 0; bus.iReq1 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Raise the selected requests together and hold each until it is acked.
  task automatic issue(input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                       output int t0);
    bit w0, w1;
    w0 = r0; w1 = r1;
    @(posedge clock); #1;
    t0 = cyc;
    bus.iWe0 = we0; bus.iAddr0 = a0; bus.iWData0 = d0; bus.iReq0 = r0;
    bus.iWe1 = we1; bus.iAddr1 = a1; bus.iWData1 = d1; bus.iReq1 = r1;
    for (int k = 0; k < 40 && (w0 || w1); k++) begin
      @(posedge clock); #1;
      if (w0 && bus.oAck0) begin bus.iReq0 = 0; w0 = 0; end
      if (w1 && bus.oAck1) begin bus.iReq1 = 0; w1 = 0; end
    end
    chk("ack_timeout", 32'({w0, w1}), 32'h0);
    bus.iReq0 = 0; bus.iReq1 = 0;
    @(negedge clock); #1;
  endtask

  task automatic issue1(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int t0);
    if (p) issue(0, 0, 32'h0, 32'h0, 1, we, a, d, t0);
    else   issue(1, we, a, d, 0, 0, 32'h0, 32'h0, t0);
  endtask

  initial begin
    int t0, n;
    logic [31:0] snap [DEPTH];
    logic [31:0] pre, a;
    logic [31:0] bad_addr [3];
    bus.iReq0 = 0; bus.iReq1 = 0; bus.iWe0 = 0; bus.iWe1 = 0;
    bus.iAddr0 = '0; bus.iAddr1 = '0; bus.iWData0 = '0; bus.iWData1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom; model_mem[i] = mem[i];
    end
    mem[1] = 32'd100; model_mem[1] = 32'd100;

    // 1: single read by port 0
    do_reset();
    clear_log();
    issue1(0, 0, 32'h10010004, 32'h0, t0);
    chk("t1_nacks", 32'(ack_port.size()), 32'd1);
    if (ack_port.size() >= 1) begin
      chk("t1_port",    32'(ack_port[0]), 32'd0);
      chk("t1_latency", 32'(ack_cyc[0] - t0), 32'd2);
      chk("t1_rdata",   ack_rdata[0], 32'd100);
      chk("t1_err",     32'(ack_err[0]), 32'd0);
    end
    $display("t1 read p0 0x10010004 acks=%0d", ack_port.size());

    // 2: simultaneous write (p0) then read (p1) of the same word
    do_reset();
    clear_log();
    issue(1, 1, 32'h10010010, 32'hDEADBEEF, 1, 0, 32'h10010010, 32'h0, t0);
    chk("t2_nacks", 32'(ack_port.size()), 32'd2);
    if (ack_port.size() >= 2) begin
      chk("t2_first_port",  32'(ack_port[0]), 32'd0);
      chk("t2_first_lat",   32'(ack_cyc[0] - t0), 32'd2);
      chk("t2_second_port", 32'(ack_port[1]), 32'd1);
      chk("t2_second_lat",  32'(ack_cyc[1] - t0), 32'd5);
      chk("t2_rdata",       ack_rdata[1], 32'hDEADBEEF);
    end
    $display("t2 p0 write / p1 read 0x10010010 acks=%0d", ack_port.size());

    // 3: both ports hold their requests for six transactions
    do_reset();
    clear_log();
    @(posedge clock); #1;
    bus.iWe0 = 0; bus.iAddr0 = 32'h10010020; bus.iReq0 = 1;
    bus.iWe1 = 0; bus.iAddr1 = 32'h10010024; bus.iReq1 = 1;
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(posedge clock); #1;
      if (bus.oAck0 || bus.oAck1) n++;
    end
    bus.iReq0 = 0; bus.iReq1 = 0;
    @(negedge clock); #1;
    chk("t3_nacks", 32'(ack_port.size()), 32'd6);
    for (int i = 0; i < ack_port.size() && i < 6; i++) begin
      chk("t3_order", 32'(ack_port[i]), 32'(i % 2));
      if (i > 0) chk("t3_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    $display("t3 continuous contention acks=%0d", ack_port.size());

    // 4: misaligned, below-range and above-range accesses
    do_reset();
    for (int i = 0; i < DEPTH; i++) snap[i] = mem[i];
    bad_addr[0] = 32'h10010002; bad_addr[1] = 32'h1000FFFC; bad_addr[2] = 32'h10010400;
    for (int i = 0; i < 6; i++) begin
      clear_log();
      issue1(i[0], i[1], bad_addr[i % 3], 32'hA5A5A5A5, t0);
      chk("t4_nacks", 32'(ack_port.size()), 32'd1);
      if (ack_port.size() >= 1) begin
        chk("t4_err",     32'(ack_err[0]), 32'd1);
        chk("t4_latency", 32'(ack_cyc[0] - t0), 32'd2);
      end
      $display("t4 port%0d we=%0d addr=%h err=%0d", i[0], i[1], bad_addr[i % 3],
               ack_err.size() > 0 ? ack_err[0] : -1);
    end
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== snap[i]) n++;
    chk("t4_mem_unchanged", 32'(n), 32'd0);

    // 5: reset asserted during the ACCESS cycle of a write
    do_reset();
    pre = mem[2];
    clear_log();
    @(posedge clock); #1;
    bus.iWe0 = 1; bus.iAddr0 = 32'h10010008; bus.iWData0 = 32'h55; bus.iReq0 = 1;
    @(posedge clock); #1;
    chk("t5_strobe_before", 32'(bus.oMemWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_strobe_drop", 32'(bus.oMemWrite), 32'd0);
    chk("t5_no_ack",      32'(bus.oAck0), 32'd0);
    bus.iReq0 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("t5_no_ack_logged", 32'(ack_port.size()), 32'd0);
    chk("t5_mem2", mem[2], pre);
    clear_log();
    issue(1, 0, 32'h10010008, 32'h0, 1, 0, 32'h1001000C, 32'h0, t0);
    if (ack_port.size() >= 1) chk("t5_p0_first", 32'(ack_port[0]), 32'd0);
    else                      chk("t5_p0_first", 32'hFFFFFFFF, 32'd0);
    $display("t5 reset mid-write, mem[2]=%h", mem[2]);

    // 6: port 0 re-requests right after every ack
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem[10+i] = 32'h1000 + 32'(i); model_mem[10+i] = mem[10+i];
    end
    clear_log();
    for (int i = 0; i < 4; i++) issue1(0, 0, BASE + 32'(4 * (10 + i)), 32'h0, t0);
    chk("t6_nacks", 32'(ack_port.size()), 32'd4);
    for (int i = 0; i < ack_port.size() && i < 4; i++) begin
      chk("t6_rdata", ack_rdata[i], 32'h1000 + 32'(i));
      if (i > 0) chk("t6_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    $display("t6 back-to-back reads acks=%0d", ack_port.size());

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      bit r0, r1, we0, we1;
      logic [31:0] a0, a1;
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1;
      we0 = 1'($urandom); we1 = 1'($urandom);
      for (int p = 0; p < 2; p++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        else if (sel == 1) a = BASE - 32'(4 * $urandom_range(1, 100));
        else if (sel == 2) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 100));
        else               a = BASE + 32'(4 * $urandom_range(0, 15));
        if (p == 0) a0 = a; else a1 = a;
      end
      clear_log();
      issue(r0, we0, a0, $urandom, r1, we1, a1, $urandom, t0);
      $display("rand %0d: req=%0d%0d a0=%h a1=%h acks=%0d", i, r0, r1, a0, a1, ack_port.size());
    end

    n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== model_mem[i]) n++;
    chk("mem_final", 32'(n), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
